fault_injection_ctrl: RTL and testbench
=======================================

FAULT_INJECTION_CTRL -- requirements
Module: fault_injection_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 8; it is the width of the protected data bus.
REQ-002 Parameter CNT_W SHALL default to 16; it is the width of the delay and duration counters.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: the synchronous, active-high reset.
REQ-005 Port data_i SHALL be an input, WIDTH bits: the fault-free data.
REQ-006 Port data_o SHALL be an output, WIDTH bits: the registered data after any fault is applied.
REQ-007 Ports cfg_valid (input, 1 bit) and cfg_ready (output, 1 bit) SHALL form the configuration handshake.
REQ-008 Port cfg_mode SHALL be an input, 2 bits: 00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 toggle (flip on alternate INJECT cycles).
REQ-009 Port cfg_mask SHALL be an input, WIDTH bits: the target bits, where 1 means the bit is faulted.
REQ-010 Ports cfg_delay and cfg_dur SHALL be inputs, CNT_W bits each: the trigger-to-inject delay and the inject duration, both in cycles.
REQ-011 Port trig_i SHALL be an input, 1 bit: the injection trigger.
REQ-012 Port abort_i SHALL be an input, 1 bit: cancels any operation.
REQ-013 Port active_o SHALL be an output, 1 bit: high while in INJECT.
REQ-014 Port done_o SHALL be an output, 1 bit: a one-cycle pulse when an injection completes.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED, DELAY, INJECT.
REQ-016 cfg_ready SHALL be 1 only in IDLE. On cfg_valid&&cfg_ready the block SHALL latch mode, mask, delay and dur, and SHALL enter ARMED next cycle.
REQ-017 In ARMED, on trig_i=1 the FSM SHALL enter DELAY with counter=cfg_delay-1; if cfg_delay==0 it SHALL enter INJECT directly.
REQ-018 In DELAY, the counter SHALL decrement each cycle; at 0 the FSM SHALL enter INJECT next cycle, so the first faulted sample is data_i exactly cfg_delay+1 cycles after trig.
REQ-019 INJECT SHALL last cfg_dur cycles, then the FSM SHALL return to IDLE with done_o=1 for exactly one cycle.
REQ-020 If cfg_dur==0, INJECT SHALL be permanent until abort_i or rst, and done_o SHALL never pulse.
REQ-021 data_o SHALL equal the fault-applied data_i registered with 1-cycle latency. Faults SHALL apply to data_i sampled while the state is INJECT: &~mask, |mask, ^mask, or ^(mask & phase), where phase starts at 1 and inverts every INJECT cycle.
REQ-022 Outside INJECT, data_o SHALL equal data_i delayed one cycle, bit-exact.
REQ-023 abort_i SHALL force IDLE next cycle from any state, with no done_o; abort_i SHALL win over a simultaneous trig_i or counter expiry.
REQ-024 trig_i outside ARMED SHALL be ignored; trig_i is level-sampled, so once in ARMED the first cycle with trig_i=1 SHALL fire.
REQ-025 The counters SHALL not wrap: the maximum cfg_delay/cfg_dur (2^CNT_W-1) SHALL be honoured exactly.

Reset
REQ-026 On rst=1: state=IDLE, data_o=0, active_o=0, done_o=0, cfg_ready=1 in the following cycle, and all latched configuration and counters cleared.
REQ-027 rst SHALL have priority over every input, including mid-DELAY or mid-INJECT.

Configuration
REQ-028 Macro FAULT_INJ_EVENT_CNT_EN, when defined, SHALL add the output inj_count_o (16 bits). It SHALL increment, saturating at 0xFFFF, on each entry into INJECT, and SHALL reset to 0.
REQ-029 Without FAULT_INJ_EVENT_CNT_EN, the port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-030 Package fault_inj_pkg SHALL hold the mode encoding constants (FI_SA0, FI_SA1, FI_FLIP, FI_TOGGLE) and the FSM state typedef.
REQ-031 The shared down-counter SHALL be the sub-module fi_down_counter, with load, decrement and zero flag, parameterised by CNT_W.

Verification
REQ-032 Pass-through: with no configuration, data_i=0xA5 SHALL give data_o=0xA5 one cycle later, with active_o=0.
REQ-033 Stuck-at-1: mode=01, mask=0x0F, delay=3, dur=4, trig, data_i=0xA0 SHALL give data_o=0xAF on exactly 4 consecutive cycles starting 5 cycles after trig, then done_o=1 for one cycle.
REQ-034 Toggle: mode=11, mask=0xFF, delay=0, dur=4, data_i=0x00 SHALL give data_o sequence 0xFF,0x00,0xFF,0x00.
REQ-035 Abort: abort_i asserted on the 2nd INJECT cycle of a dur=10 run SHALL return data_o to pass-through after 2 cycles, with no done_o and cfg_ready=1.
REQ-036 Permanent and reset: dur=0 SHALL keep active_o=1 for 1000 cycles; rst mid-INJECT SHALL give all outputs their reset values next cycle.
REQ-037 With FAULT_INJ_EVENT_CNT_EN defined, 3 completed injections plus 1 abort-in-DELAY SHALL give inj_count_o=3.

Source files
------------

// File: rtl/fault_inj_pkg.sv
// fault_inj_pkg -- shared constants and types for the fault injection controller.
//   FI_SA0 / FI_SA1 / FI_FLIP / FI_TOGGLE : cfg_mode encodings
//   fi_state_t                           : controller FSM state
//   FI_EVT_W                             : width of the optional injection event counter
package fault_inj_pkg;

    localparam logic [1:0] FI_SA0    = 2'b00;  // data & ~mask
    localparam logic [1:0] FI_SA1    = 2'b01;  // data |  mask
    localparam logic [1:0] FI_FLIP   = 2'b10;  // data ^  mask
    localparam logic [1:0] FI_TOGGLE = 2'b11;  // data ^ (mask & phase), phase alternates

    localparam int FI_EVT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_INJECT = 2'd3
    } fi_state_t;

endpackage

// File: rtl/fi_down_counter.sv
// fi_down_counter -- loadable down-counter shared by the DELAY and INJECT phases.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero, never wraps
//   zero      : count == 0
module fi_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fault_injection_ctrl.sv
// fault_injection_ctrl -- applies a configurable fault to a registered data path.
// A configuration (mode, mask, delay, duration) is accepted in IDLE, the block
// arms, and a trigger starts a delay followed by an injection window during which
// data_i is corrupted before being registered onto data_o.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   data_i / data_o       : fault-free input / registered (possibly faulted) output
//   cfg_valid / cfg_ready : configuration handshake (ready only in IDLE)
//   cfg_mode, cfg_mask    : fault type and target bits
//   cfg_delay, cfg_dur    : trigger-to-inject delay and inject duration (0 = permanent)
//   trig_i, abort_i       : trigger (level, honoured in ARMED) / cancel to IDLE
//   active_o, done_o      : in INJECT / one-cycle completion pulse
//   inj_count_o           : saturating count of INJECT entries, only when
//                           FAULT_INJ_EVENT_CNT_EN is defined
module fault_injection_ctrl
    import fault_inj_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_dur,
    input  logic             trig_i,
    input  logic             abort_i,
    output logic             active_o,
    output logic             done_o
`ifdef FAULT_INJ_EVENT_CNT_EN
    ,
    output logic [FI_EVT_W-1:0] inj_count_o
`endif
);

    fi_state_t        state, next_state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] delay_q, dur_q;
    logic             phase;

    logic             cfg_take;
    logic             done_set;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             inject_entry;
    logic [WIDTH-1:0] fault_mask, data_fault;

    fi_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // The counter is loaded with N-1 on phase entry so that a phase of N cycles
    // ends on the cycle the counter reads zero; N = 2^CNT_W-1 therefore fits.
    always_comb begin
        next_state = state;
        cfg_take   = 1'b0;
        done_set   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    next_state = ST_ARMED;
                    cfg_take   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (trig_i) begin
                    cnt_load = 1'b1;
                    if (delay_q == '0) begin
                        next_state = ST_INJECT;
                        cnt_val    = dur_q - 1'b1;
                    end else begin
                        next_state = ST_DELAY;
                        cnt_val    = delay_q - 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_zero) begin
                    next_state = ST_INJECT;
                    cnt_load   = 1'b1;
                    cnt_val    = dur_q - 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_INJECT: begin
                // dur_q == 0 means a permanent fault: never leave on our own
                if (dur_q != '0) begin
                    if (cnt_zero) begin
                        next_state = ST_IDLE;
                        done_set   = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (abort_i) begin
            next_state = ST_IDLE;
            cfg_take   = 1'b0;
            done_set   = 1'b0;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
        end
    end

    assign inject_entry = (next_state == ST_INJECT) && (state != ST_INJECT);
    assign cfg_ready    = (state == ST_IDLE);
    assign active_o     = (state == ST_INJECT);

    always_comb begin
        fault_mask = (mode_q == FI_TOGGLE) ? (mask_q & {WIDTH{phase}}) : mask_q;
        data_fault = data_i;
        if (state == ST_INJECT) begin
            case (mode_q)
                FI_SA0:  data_fault = data_i & ~fault_mask;
                FI_SA1:  data_fault = data_i |  fault_mask;
                default: data_fault = data_i ^  fault_mask;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= FI_SA0;
            mask_q  <= '0;
            delay_q <= '0;
            dur_q   <= '0;
            phase   <= 1'b0;
            data_o  <= '0;
            done_o  <= 1'b0;
        end else begin
            if (cfg_take) begin
                mode_q  <= cfg_mode;
                mask_q  <= cfg_mask;
                delay_q <= cfg_delay;
                dur_q   <= cfg_dur;
            end
            // toggle phase is 1 on the first INJECT cycle and alternates after
            if (inject_entry)            phase <= 1'b1;
            else if (state == ST_INJECT) phase <= ~phase;
            data_o <= data_fault;
            done_o <= done_set;
        end
    end

`ifdef FAULT_INJ_EVENT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_count_o <= '0;
        end else if (inject_entry && (inj_count_o != {FI_EVT_W{1'b1}})) begin
            inj_count_o <= inj_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fault_injection_ctrl.sv
// Bench for fault_injection_ctrl. A timeline reference model tracks, in absolute
// cycle numbers, when the block is busy, when its injection window runs and when
// done is due; every cycle's outputs are compared against it, plus directed checks.
module tb_fault_injection_ctrl;

    localparam int W  = 8;
    localparam int CW = 6;
    localparam longint INF = 64'h3fff_ffff_ffff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_i, data_o;
    logic          cfg_valid, cfg_ready;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  cfg_mask;
    logic [CW-1:0] cfg_delay, cfg_dur;
    logic          trig_i, abort_i, active_o, done_o;
`ifdef FAULT_INJ_EVENT_CNT_EN
    logic [15:0]   inj_count_o;
`endif

    fault_injection_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .data_o    (data_o),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_mask  (cfg_mask),
        .cfg_delay (cfg_delay),
        .cfg_dur   (cfg_dur),
        .trig_i    (trig_i),
        .abort_i   (abort_i),
        .active_o  (active_o),
        .done_o    (done_o)
`ifdef FAULT_INJ_EVENT_CNT_EN
        ,
        .inj_count_o (inj_count_o)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model (timeline of events) ----------------
    longint cyc = 0;
    longint arm_s = 0, win_s = INF, win_e = -1, busy_s = 1, busy_e = 0, done_cyc = -1;
    bit     armed_p = 0;
    logic [1:0]   m_mode = 2'd0;
    logic [W-1:0] m_mask = '0;
    int     m_delay = 0, m_dur = 0, m_cnt = 0;
    int     n_checks = 0, n_fails = 0;
    bit     hold_din = 0;

    function automatic bit in_win(longint k);
        return (k >= win_s) && (k <= win_e);
    endfunction

    function automatic bit ready_at(longint k);
        return !((k >= busy_s) && (k <= busy_e));
    endfunction

    function automatic logic [W-1:0] model_out(logic [W-1:0] d, longint k);
        if (!in_win(k)) return d;
        case (m_mode)
            2'd0:    return d & ~m_mask;
            2'd1:    return d | m_mask;
            2'd2:    return d ^ m_mask;
            default: return (((k - win_s) % 2) == 0) ? (d ^ m_mask) : d;
        endcase
    endfunction

    // Update the timeline with the inputs applied during cycle k.
    task automatic model_step(longint k);
        if (rst || abort_i) begin
            if (win_s > k)  win_s  = INF;
            if (win_e > k)  win_e  = k;
            if (busy_e > k) busy_e = k;
            done_cyc = -1;
            armed_p  = 0;
            if (rst) begin
                m_mode = 2'd0; m_mask = '0; m_delay = 0; m_dur = 0; m_cnt = 0;
            end
        end else if (ready_at(k) && cfg_valid) begin
            m_mode = cfg_mode; m_mask = cfg_mask;
            m_delay = int'(cfg_delay); m_dur = int'(cfg_dur);
            armed_p = 1; arm_s = k + 1; busy_s = k + 1; busy_e = INF;
        end else if (armed_p && k >= arm_s && trig_i) begin
            armed_p  = 0;
            win_s    = k + m_delay + 1;
            win_e    = (m_dur != 0) ? k + m_delay + m_dur : INF;
            busy_e   = win_e;
            done_cyc = (m_dur != 0) ? win_e + 1 : -1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: compute expectations, advance, sample #1 after the edge.
    task automatic tick();
        logic [W-1:0] ed;
        longint k;
        k  = cyc;
        ed = rst ? '0 : model_out(data_i, k);
        model_step(k);
        @(posedge clk); #1;
        cyc++;
        if (cyc == win_s) m_cnt++;
        chk("data_o",    16'(data_o),    16'(ed));
        chk("active_o",  16'(active_o),  16'(in_win(cyc)));
        chk("done_o",    16'(done_o),    16'(cyc == done_cyc));
        chk("cfg_ready", 16'(cfg_ready), 16'(ready_at(cyc)));
`ifdef FAULT_INJ_EVENT_CNT_EN
        chk("inj_count", inj_count_o, 16'(m_cnt));
`endif
    endtask

    task automatic step();
        if (!hold_din) data_i = W'($urandom);
        tick();
    endtask

    task automatic configure(input logic [1:0] mode, input logic [W-1:0] mask, input int d, input int n);
        cfg_valid = 1'b1; cfg_mode = mode; cfg_mask = mask;
        cfg_delay = CW'(d); cfg_dur = CW'(n);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic fire();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        for (int i = 0; i < budget && !ready_at(cyc); i++) step();
        chk(tag, 16'(cfg_ready), 16'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        longint t, first;
        int hits, act;
        logic [W-1:0] tog_exp [4];
        tog_exp[0] = 8'hFF; tog_exp[1] = 8'h00; tog_exp[2] = 8'hFF; tog_exp[3] = 8'h00;

        rst = 1'b1; data_i = '0; cfg_valid = 1'b0; cfg_mode = '0; cfg_mask = '0;
        cfg_delay = '0; cfg_dur = '0; trig_i = 1'b0; abort_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_data_o", 16'(data_o), 16'h0);
        chk("rst_ready",  16'(cfg_ready), 16'd1);

        // pass-through with no configuration; trig while IDLE is ignored
        hold_din = 1; data_i = 8'hA5; trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk("pass_A5",     16'(data_o),   16'h00A5);
        chk("pass_active", 16'(active_o), 16'd0);

        // stuck-at-1, delay 3, dur 4
        data_i = 8'hA0;
        configure(2'b01, 8'h0F, 3, 4);
        t = cyc; first = -1; hits = 0;
        fire();
        for (int i = 0; i < 12; i++) begin
            if (data_o == 8'hAF) begin
                if (first < 0) first = cyc;
                hits++;
            end
            tick();
        end
        chk("sa1_start", 16'(first - t), 16'd5);
        chk("sa1_hits",  16'(hits),      16'd4);

        // toggle, delay 0, dur 4
        data_i = 8'h00;
        configure(2'b11, 8'hFF, 0, 4);
        fire();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("toggle_seq", 16'(data_o), 16'(tog_exp[i]));
            tick();
        end
        tick(); tick();

        // abort on 2nd INJECT cycle of a dur=10 run
        hold_din = 0;
        configure(2'b10, 8'hFF, 0, 10);
        fire();
        step();
        abort_i = 1'b1; step(); abort_i = 1'b0;
        chk("abort_ready", 16'(cfg_ready), 16'd1);
        step(); step(); step();

        // boundaries: shortest run and maximum delay/duration
        configure(2'b00, 8'hFF, 0, 1);
        fire();
        step(); step(); step();
        configure(2'b10, 8'h3C, (1 << CW) - 1, (1 << CW) - 1);
        fire();
        wait_ready(140, "max_done");

        // randomized runs with trigger/abort noise
        for (int r = 0; r < 10; r++) begin
            trig_i = 1'b1; step(); trig_i = 1'b0;
            configure(2'($urandom_range(0, 3)), W'($urandom), $urandom_range(0, 5), $urandom_range(1, 6));
            for (int i = 0; i < 25; i++) begin
                trig_i  = 1'($urandom_range(0, 1));
                abort_i = ($urandom_range(0, 15) == 0);
                step();
            end
            abort_i = 1'b0;
            trig_i = 1'b1; step(); trig_i = 1'b0;
            wait_ready(20, "rand_idle");
        end

        // permanent fault, then reset mid-INJECT
        configure(2'b01, 8'hF0, 2, 0);
        fire();
        step(); step();
        act = 0;
        for (int i = 0; i < 1000; i++) begin
            if (active_o) act++;
            step();
        end
        chk("perm_active", 16'(act), 16'd1000);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_data",   16'(data_o),    16'h0);
        chk("rst_mid_active", 16'(active_o),  16'd0);
        chk("rst_mid_done",   16'(done_o),    16'd0);
        chk("rst_mid_ready",  16'(cfg_ready), 16'd1);

`ifdef FAULT_INJ_EVENT_CNT_EN
        for (int i = 0; i < 3; i++) begin
            configure(2'b10, 8'h01, 1, 2);
            fire();
            repeat (5) step();
        end
        configure(2'b10, 8'h01, 4, 2);
        fire();
        step();
        abort_i = 1'b1; step(); abort_i = 1'b0;
        step();
        chk("inj_count_3", inj_count_o, 16'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
